// File: rtl/obi_arbiter_2m.sv
// Two-master OBI arbiter: muxes requests to one slave port and routes responses back via an in-order ID FIFO.
// Define OBI_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise master 0 has fixed priority.
module obi_arbiter_2m #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_be,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_be,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              s_req,
  output logic              s_we,
  output logic [3:0]        s_be,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  input  logic              s_gnt,
  input  logic              s_rvalid,
  input  logic [31:0]       s_rdata,
  input  logic              s_err,
  output logic              protocol_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  master_e       id_fifo [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          lock;
  master_e       locked_id;
  master_e       sel;
  master_e       head;
  logic          sel_req;
  logic          push;
  logic          pop;
  logic          perr_q;
`ifdef OBI_ARB_ROUND_ROBIN_EN
  master_e       prio;
`endif

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // A stalled request keeps its master selected until the slave grants it.
  always_comb begin
    sel = M0;
    if (lock) begin
      sel = locked_id;
    end else if (m0_req && m1_req) begin
`ifdef OBI_ARB_ROUND_ROBIN_EN
      sel = prio;
`else
      sel = M0;
`endif
    end else if (m1_req) begin
      sel = M1;
    end
  end

  always_comb begin
    s_req   = 1'b0;
    s_we    = 1'b0;
    s_be    = '0;
    s_addr  = '0;
    s_wdata = '0;
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    sel_req = (sel == M1) ? m1_req : m0_req;
    if (sel_req && (count < MAX_CNT)) begin
      s_req = 1'b1;
      if (sel == M1) begin
        s_we    = m1_we;
        s_be    = m1_be;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        m1_gnt  = s_gnt;
      end else begin
        s_we    = m0_we;
        s_be    = m0_be;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        m0_gnt  = s_gnt;
      end
    end
  end

  assign push = s_req && s_gnt;
  assign pop  = s_rvalid && (count != '0);
  assign head = id_fifo[rd_ptr];

  // Responses with nothing outstanding are dropped here and only flagged.
  always_comb begin
    m0_rvalid = 1'b0;
    m0_rdata  = '0;
    m0_err    = 1'b0;
    m1_rvalid = 1'b0;
    m1_rdata  = '0;
    m1_err    = 1'b0;
    if (pop) begin
      if (head == M1) begin
        m1_rvalid = 1'b1;
        m1_rdata  = s_rdata;
        m1_err    = s_err;
      end else begin
        m0_rvalid = 1'b1;
        m0_rdata  = s_rdata;
        m0_err    = s_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      id_fifo[wr_ptr] <= sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      lock      <= 1'b0;
      locked_id <= M0;
      perr_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push) begin
        lock <= 1'b0;
      end else if (s_req) begin
        lock      <= 1'b1;
        locked_id <= sel;
      end
      if (s_rvalid && (count == '0)) begin
        perr_q <= 1'b1;
      end
    end
  end

`ifdef OBI_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= M0;
    end else if (push) begin
      prio <= (prio == M0) ? M1 : M0;
    end
  end
`endif

  assign protocol_err = perr_q;

endmodule
